npc_redirect: RTL and testbench

NPC_REDIRECT -- requirements
Module: npc_redirect

---
 rtl/npc_redirect_pkg.sv | 23 ++
 rtl/npc_redirect_if.sv | 32 +++
 rtl/npc_redirect_calc.sv | 71 +++++++
 rtl/npc_redirect.sv | 123 ++++++++++++
 tb/tb_npc_redirect.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/npc_redirect_pkg.sv
// Shared encodings for the next-PC redirect slice: decode kinds, FSM states, reset target.
package npc_redirect_pkg;

    localparam logic [31:0] PC_INIT_DEFAULT = 32'h0000_3000;

    typedef enum logic [2:0] {
        KIND_NONE = 3'd0,
        KIND_BEQ  = 3'd1,
        KIND_BNE  = 3'd2,
        KIND_J    = 3'd3,
        KIND_JAL  = 3'd4,
        KIND_JR   = 3'd5,
        KIND_JALR = 3'd6,
        KIND_RSVD = 3'd7
    } d_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_OPND = 2'd1,
        ST_HOLD      = 2'd2
    } npc_state_e;

endpackage

// File: rtl/npc_redirect_if.sv
// Decode-to-PC redirect bundle; slave is the redirect block, master is the decode/PC side.
interface npc_redirect_if #(
    parameter int unsigned CNT_W = 16
);
    logic              d_valid;
    logic [31:0]       d_pc;
    logic [2:0]        d_kind;
    logic [15:0]       d_imm16;
    logic [25:0]       d_index26;
    logic [31:0]       rs_val;
    logic [31:0]       rt_val;
    logic              opnd_ready;
    logic              pc_en;
    logic              flush;
    logic              redirect_valid;
    logic [31:0]       redirect_npc;
    logic              d_stall;
    logic [31:0]       link_addr;
    logic [CNT_W-1:0]  taken_cnt;

    modport slave (
        input  d_valid, d_pc, d_kind, d_imm16, d_index26,
        input  rs_val, rt_val, opnd_ready, pc_en, flush,
        output redirect_valid, redirect_npc, d_stall, link_addr, taken_cnt
    );

    modport master (
        output d_valid, d_pc, d_kind, d_imm16, d_index26,
        output rs_val, rt_val, opnd_ready, pc_en, flush,
        input  redirect_valid, redirect_npc, d_stall, link_addr, taken_cnt
    );
endinterface

// File: rtl/npc_redirect_calc.sv
// Purely combinational branch/jump target, taken condition and link address.
module npc_calc
    import npc_redirect_pkg::*;
(
    input  d_kind_e     i_kind,
    input  logic [31:0] i_pc,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_index26,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic        o_active,
    output logic        o_need_opnd,
    output logic        o_taken,
    output logic [31:0] o_target,
    output logic [31:0] o_link
);
    logic [31:0] w_pc4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;

    assign w_pc4       = i_pc + 32'd4;
    assign w_br_target = w_pc4 + {{14{i_imm16[15]}}, i_imm16, 2'b00};
    assign w_j_target  = {w_pc4[31:28], i_index26, 2'b00};

    always_comb begin
        o_active    = 1'b0;
        o_need_opnd = 1'b0;
        o_taken     = 1'b0;
        o_target    = '0;
        o_link      = '0;
        case (i_kind)
            KIND_BEQ: begin
                o_active    = 1'b1;
                o_need_opnd = 1'b1;
                o_taken     = (i_rs == i_rt);
                o_target    = w_br_target;
            end
            KIND_BNE: begin
                o_active    = 1'b1;
                o_need_opnd = 1'b1;
                o_taken     = (i_rs != i_rt);
                o_target    = w_br_target;
            end
            KIND_J: begin
                o_active = 1'b1;
                o_taken  = 1'b1;
                o_target = w_j_target;
            end
            KIND_JAL: begin
                o_active = 1'b1;
                o_taken  = 1'b1;
                o_target = w_j_target;
                o_link   = i_pc + 32'd8;
            end
            KIND_JR: begin
                o_active    = 1'b1;
                o_need_opnd = 1'b1;
                o_taken     = 1'b1;
                o_target    = i_rs;
            end
            KIND_JALR: begin
                o_active    = 1'b1;
                o_need_opnd = 1'b1;
                o_taken     = 1'b1;
                o_target    = i_rs;
                o_link      = i_pc + 32'd8;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/npc_redirect.sv
// Next-PC redirect control: zero-latency redirect when the PC stage accepts,
// otherwise the target is parked in a hold register until it does.
module npc_redirect
    import npc_redirect_pkg::*;
#(
    parameter logic [31:0] PC_INIT = PC_INIT_DEFAULT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic         clk,
    input  logic         reset,
    npc_redirect_if.slave bus
);
    npc_state_e       r_state;
    npc_state_e       w_next;
    logic [31:0]      r_hold;
    logic [CNT_W-1:0] r_cnt;

    logic        w_active;
    logic        w_need;
    logic        w_taken;
    logic [31:0] w_target;
    logic [31:0] w_link;
    logic        w_resolve;
    logic        w_rv;
    logic [31:0] w_npc;
    logic        w_stall;
    logic        w_inc;
    logic        w_cap;

    npc_calc u_calc (
        .i_kind      (d_kind_e'(bus.d_kind)),
        .i_pc        (bus.d_pc),
        .i_imm16     (bus.d_imm16),
        .i_index26   (bus.d_index26),
        .i_rs        (bus.rs_val),
        .i_rt        (bus.rt_val),
        .o_active    (w_active),
        .o_need_opnd (w_need),
        .o_taken     (w_taken),
        .o_target    (w_target),
        .o_link      (w_link)
    );

    always_comb begin
        w_next    = r_state;
        w_resolve = 1'b0;
        w_rv      = 1'b0;
        w_npc     = '0;
        w_stall   = 1'b0;
        w_inc     = 1'b0;
        w_cap     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.d_valid && w_active) begin
                    if (w_need && !bus.opnd_ready) begin
                        w_stall = 1'b1;
                        w_next  = ST_WAIT_OPND;
                    end else begin
                        w_resolve = 1'b1;
                    end
                end
            end
            ST_WAIT_OPND: begin
                if (bus.opnd_ready) w_resolve = 1'b1;
                else                w_stall   = 1'b1;
            end
            ST_HOLD: begin
                w_rv    = 1'b1;
                w_npc   = r_hold;
                w_stall = 1'b1;
                if (bus.pc_en) begin
                    w_next = ST_IDLE;
                    w_inc  = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase

        if (w_resolve) begin
            w_next = ST_IDLE;
            if (w_taken) begin
                w_rv  = 1'b1;
                w_npc = w_target;
                if (bus.pc_en) begin
                    w_inc = 1'b1;
                end else begin
                    w_cap   = 1'b1;
                    w_stall = 1'b1;
                    w_next  = ST_HOLD;
                end
            end
        end

        // flush wins over any decision, including a parked redirect
        if (bus.flush) begin
            w_next  = ST_IDLE;
            w_rv    = 1'b0;
            w_npc   = '0;
            w_stall = 1'b0;
            w_inc   = 1'b0;
            w_cap   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_hold  <= PC_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_cap) r_hold <= w_target;
            if (w_inc && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // gate with reset so decode inputs cannot raise controls while reset is held
    assign bus.redirect_valid = w_rv & reset;
    assign bus.redirect_npc   = reset ? w_npc : '0;
    assign bus.d_stall        = w_stall & reset;
    assign bus.link_addr      = w_link;
    assign bus.taken_cnt      = r_cnt;
endmodule

// File: tb/tb_npc_redirect.sv
// Directed self-checking bench for npc_redirect, plus a CNT_W=2 instance for saturation.
module tb_npc_redirect;
    import npc_redirect_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    npc_redirect_if #(.CNT_W(16)) bus  ();
    npc_redirect_if #(.CNT_W(2))  bus2 ();

    npc_redirect #(.PC_INIT(32'h0000_3000), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    npc_redirect #(.PC_INIT(32'h0000_3000), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive_idle();
        bus.d_valid    = 1'b0;
        bus.d_pc       = '0;
        bus.d_kind     = KIND_NONE;
        bus.d_imm16    = '0;
        bus.d_index26  = '0;
        bus.rs_val     = '0;
        bus.rt_val     = '0;
        bus.opnd_ready = 1'b0;
        bus.pc_en      = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic drive_idle2();
        bus2.d_valid    = 1'b0;
        bus2.d_pc       = '0;
        bus2.d_kind     = KIND_NONE;
        bus2.d_imm16    = '0;
        bus2.d_index26  = '0;
        bus2.rs_val     = '0;
        bus2.rt_val     = '0;
        bus2.opnd_ready = 1'b0;
        bus2.pc_en      = 1'b0;
        bus2.flush      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_idle();
        drive_idle2();
        #1;
        n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv: got %b expected 0", bus.redirect_valid); end
        n_checks++; if (bus.d_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.d_stall); end
        n_checks++; if (bus.taken_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.taken_cnt); end
        n_checks++; if (bus2.taken_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt2: got %0d expected 0", bus2.taken_cnt); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.redirect_valid !== 1'b0 || bus.d_stall !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: rv=%b stall=%b expected 0/0", bus.redirect_valid, bus.d_stall); end
    endtask

    task automatic test_beq_taken();
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_kind = KIND_BEQ; bus.d_pc = 32'h0000_3000; bus.d_imm16 = 16'h0004;
        bus.rs_val = 32'd5; bus.rt_val = 32'd5; bus.opnd_ready = 1'b1; bus.pc_en = 1'b1;
        #1;
        n_checks++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL beq_rv: got %b expected 1", bus.redirect_valid); end
        n_checks++; if (bus.redirect_npc !== 32'h0000_3014) begin n_fail++; $display("FAIL beq_npc: got %h expected 00003014", bus.redirect_npc); end
        n_checks++; if (bus.d_stall !== 1'b0) begin n_fail++; $display("FAIL beq_stall: got %b expected 0", bus.d_stall); end
        @(posedge clk); #1;
        n_checks++; if (bus.taken_cnt !== 16'd1) begin n_fail++; $display("FAIL beq_cnt: got %0d expected 1", bus.taken_cnt); end
        drive_idle();
    endtask

    task automatic test_bne();
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_kind = KIND_BNE; bus.d_pc = 32'h0000_3010; bus.d_imm16 = 16'hFFFF;
        bus.rs_val = 32'd7; bus.rt_val = 32'd7; bus.opnd_ready = 1'b1; bus.pc_en = 1'b1;
        #1;
        n_checks++; if (bus.redirect_valid !== 1'b0 || bus.d_stall !== 1'b0) begin n_fail++; $display("FAIL bne_nt: rv=%b stall=%b expected 0/0", bus.redirect_valid, bus.d_stall); end
        @(posedge clk); #1;
        n_checks++; if (bus.taken_cnt !== 16'd1) begin n_fail++; $display("FAIL bne_nt_cnt: got %0d expected 1", bus.taken_cnt); end
        @(negedge clk);
        bus.rt_val = 32'd8;
        #1;
        n_checks++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL bne_rv: got %b expected 1", bus.redirect_valid); end
        n_checks++; if (bus.redirect_npc !== 32'h0000_3010) begin n_fail++; $display("FAIL bne_npc: got %h expected 00003010", bus.redirect_npc); end
        @(posedge clk); #1;
        n_checks++; if (bus.taken_cnt !== 16'd2) begin n_fail++; $display("FAIL bne_cnt: got %0d expected 2", bus.taken_cnt); end
        drive_idle();
    endtask

    task automatic test_jal_hold();
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_kind = KIND_JAL; bus.d_pc = 32'h0000_3008; bus.d_index26 = 26'h0000C10;
        bus.pc_en = 1'b0;
        for (int unsigned c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_npc !== 32'h0000_3040) begin n_fail++; $display("FAIL jal_hold_c%0d: rv=%b npc=%h expected 1/00003040", c, bus.redirect_valid, bus.redirect_npc); end
            n_checks++; if (bus.d_stall !== 1'b1) begin n_fail++; $display("FAIL jal_stall_c%0d: got %b expected 1", c, bus.d_stall); end
            n_checks++; if (bus.link_addr !== 32'h0000_3010) begin n_fail++; $display("FAIL jal_link_c%0d: got %h expected 00003010", c, bus.link_addr); end
            @(negedge clk);
            // corrupt the live jump field: only the hold register may supply the target now
            bus.d_index26 = 26'h0;
        end
        bus.pc_en = 1'b1;
        #1;
        n_checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_npc !== 32'h0000_3040) begin n_fail++; $display("FAIL jal_release: rv=%b npc=%h expected 1/00003040", bus.redirect_valid, bus.redirect_npc); end
        @(posedge clk); #1;
        n_checks++; if (bus.taken_cnt !== 16'd3) begin n_fail++; $display("FAIL jal_cnt: got %0d expected 3", bus.taken_cnt); end
        drive_idle();
        #1;
        n_checks++; if (bus.redirect_valid !== 1'b0 || bus.d_stall !== 1'b0) begin n_fail++; $display("FAIL jal_idle: rv=%b stall=%b expected 0/0", bus.redirect_valid, bus.d_stall); end
    endtask

    task automatic test_jr_wait();
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_kind = KIND_JR; bus.d_pc = 32'h0000_3020; bus.rs_val = 32'hDEAD_0000;
        bus.opnd_ready = 1'b0; bus.pc_en = 1'b1;
        for (int unsigned c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (bus.d_stall !== 1'b1 || bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jr_wait_c%0d: stall=%b rv=%b expected 1/0", c, bus.d_stall, bus.redirect_valid); end
            @(negedge clk);
        end
        bus.opnd_ready = 1'b1; bus.rs_val = 32'h0000_3100;
        #1;
        n_checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_npc !== 32'h0000_3100) begin n_fail++; $display("FAIL jr_npc: rv=%b npc=%h expected 1/00003100", bus.redirect_valid, bus.redirect_npc); end
        n_checks++; if (bus.link_addr !== 32'h0) begin n_fail++; $display("FAIL jr_link: got %h expected 0", bus.link_addr); end
        @(posedge clk); #1;
        n_checks++; if (bus.taken_cnt !== 16'd4) begin n_fail++; $display("FAIL jr_cnt: got %0d expected 4", bus.taken_cnt); end
        drive_idle();
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_kind = KIND_J; bus.d_pc = 32'h0000_3000; bus.d_index26 = 26'h0000100;
        bus.pc_en = 1'b0;
        @(posedge clk); #1;
        bus.d_valid = 1'b0;
        #1;
        n_checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_npc !== 32'h0000_0400) begin n_fail++; $display("FAIL hold_before_rst: rv=%b npc=%h expected 1/00000400", bus.redirect_valid, bus.redirect_npc); end
        #1;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.redirect_valid !== 1'b0 || bus.d_stall !== 1'b0) begin n_fail++; $display("FAIL async_rst: rv=%b stall=%b expected 0/0", bus.redirect_valid, bus.d_stall); end
        n_checks++; if (bus.taken_cnt !== 16'd0) begin n_fail++; $display("FAIL async_rst_cnt: got %0d expected 0", bus.taken_cnt); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL hold_discarded: rv=%b expected 0", bus.redirect_valid); end
        drive_idle();
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_kind = KIND_BEQ; bus.d_pc = 32'h0000_3000; bus.d_imm16 = 16'h0004;
        bus.rs_val = 32'd1; bus.rt_val = 32'd1; bus.opnd_ready = 1'b1; bus.pc_en = 1'b1; bus.flush = 1'b1;
        #1;
        n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL flush_rv: got %b expected 0", bus.redirect_valid); end
        @(posedge clk); #1;
        n_checks++; if (bus.taken_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_cnt: got %0d expected 0", bus.taken_cnt); end
        // park a J, then flush the held redirect
        @(negedge clk);
        drive_idle();
        bus.d_valid = 1'b1; bus.d_kind = KIND_J; bus.d_pc = 32'h0000_3000; bus.d_index26 = 26'h0000200;
        @(negedge clk);
        bus.d_valid = 1'b0; bus.flush = 1'b1;
        #1;
        n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL flush_hold_rv: got %b expected 0", bus.redirect_valid); end
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        n_checks++; if (bus.redirect_valid !== 1'b0 || bus.d_stall !== 1'b0) begin n_fail++; $display("FAIL flush_hold_idle: rv=%b stall=%b expected 0/0", bus.redirect_valid, bus.d_stall); end
        n_checks++; if (bus.taken_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_hold_cnt: got %0d expected 0", bus.taken_cnt); end
        drive_idle();
    endtask

    task automatic test_link_and_reserved();
        @(negedge clk);
        bus.d_valid = 1'b0; bus.d_kind = KIND_JALR; bus.d_pc = 32'hFFFF_FFFC;
        #1;
        n_checks++; if (bus.link_addr !== 32'h0000_0004) begin n_fail++; $display("FAIL jalr_link_wrap: got %h expected 00000004", bus.link_addr); end
        bus.d_valid = 1'b1; bus.d_kind = KIND_RSVD; bus.d_pc = 32'h0000_3000; bus.opnd_ready = 1'b1; bus.pc_en = 1'b1;
        #1;
        n_checks++; if (bus.redirect_valid !== 1'b0 || bus.d_stall !== 1'b0 || bus.link_addr !== 32'h0) begin n_fail++; $display("FAIL reserved_kind: rv=%b stall=%b link=%h expected 0/0/0", bus.redirect_valid, bus.d_stall, bus.link_addr); end
        @(posedge clk); #1;
        n_checks++; if (bus.taken_cnt !== 16'd0) begin n_fail++; $display("FAIL reserved_cnt: got %0d expected 0", bus.taken_cnt); end
        drive_idle();
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        @(negedge clk);
        bus2.d_valid = 1'b1; bus2.d_kind = KIND_J; bus2.d_pc = 32'h0000_3000; bus2.d_index26 = 26'h0000C00;
        bus2.pc_en = 1'b1;
        for (int unsigned k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_checks++; if (bus2.taken_cnt !== exp_cnt[k]) begin n_fail++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", k, bus2.taken_cnt, exp_cnt[k]); end
        end
        drive_idle2();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_beq_taken();
        test_bne();
        test_jal_hold();
        test_jr_wait();
        test_reset_mid_hold();
        test_flush();
        test_link_and_reserved();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
